// File: rtl/line_mem_if.sv
// line_mem_if: request/completion handshake between a cache and its
// line-fill/write-back responder. The 64-bit dataM line bus is not part of
// this bundle. It stays a plain inout net on the responder so that the
// tristate drivers on both sides resolve on one ordinary wire.
interface line_mem_if #(
  parameter int WORD_SIZE = 16
);
  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] addressM;
  logic                 ready;
  logic                 busy;
  logic [WORD_SIZE-1:0] rd_cnt;
  logic [WORD_SIZE-1:0] wr_cnt;

  modport master (
    output readM, writeM, addressM,
    input  ready, busy, rd_cnt, wr_cnt
  );

  modport slave (
    input  readM, writeM, addressM,
    output ready, busy, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/line_mem_responder.sv
// line_mem_responder: memory-side responder for a cache line port.
// It accepts one line read or write at a time and completes it LATENCY
// cycles after acceptance with a one-cycle ready pulse. Read lines are
// driven onto dataM only during the READ_DONE cycle.
// Optional feature macro: LINE_MEM_CNT_EN adds completed read/write
// counters. Without it, rd_cnt and wr_cnt are tied to zero.
module line_mem_responder #(
  parameter int WORD_SIZE      = 16,
  parameter int FETCH_SIZE     = 64,
  parameter int LINE_ADDR_BITS = 8,
  parameter int LATENCY        = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  line_mem_if.slave             bus,
  inout  wire  [FETCH_SIZE-1:0] dataM
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAIT,
    S_READ_DONE,
    S_WRITE_WAIT,
    S_WRITE_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_nextState;
  logic [3:0]                r_count;
  logic [3:0]                w_nextCount;
  logic [LINE_ADDR_BITS-1:0] r_index;
  logic [LINE_ADDR_BITS-1:0] w_nextIndex;
  logic                      w_drive;
  logic                      w_done;
  logic                      w_unusedAddr;

  // Line array. It has no reset, so its contents survive a reset.
  logic [FETCH_SIZE-1:0] r_mem [2**LINE_ADDR_BITS];

  // Offset bits and the aliased upper address bits do not select a line.
  assign w_unusedAddr = ^{bus.addressM[WORD_SIZE-1:LINE_ADDR_BITS+2], bus.addressM[1:0]};

  // State, wait counter and latched line index.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_index <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      r_index <= w_nextIndex;
    end
  end

  // Next-state logic. When both requests are present, the write wins.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextIndex = r_index;
    case (r_state)
      S_IDLE: begin
        if (bus.writeM) begin
          w_nextIndex = bus.addressM[LINE_ADDR_BITS+1:2];
          w_nextCount = 4'(LATENCY - 2);
          w_nextState = S_WRITE_WAIT;
        end else if (bus.readM) begin
          w_nextIndex = bus.addressM[LINE_ADDR_BITS+1:2];
          w_nextCount = 4'(LATENCY - 2);
          w_nextState = S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        if (r_count == 4'd0) w_nextState = S_READ_DONE;
        else                 w_nextCount = r_count - 4'd1;
      end
      S_WRITE_WAIT: begin
        if (r_count == 4'd0) w_nextState = S_WRITE_DONE;
        else                 w_nextCount = r_count - 4'd1;
      end
      S_READ_DONE:  w_nextState = S_IDLE;
      S_WRITE_DONE: w_nextState = S_IDLE;
      default:      w_nextState = S_IDLE;
    endcase
  end

  // Outputs are gated by reset_n. This keeps ready from pulsing and the
  // bus from being driven in a cycle where a reset is being applied.
  assign w_done    = reset_n && (r_state == S_READ_DONE || r_state == S_WRITE_DONE);
  assign w_drive   = reset_n && (r_state == S_READ_DONE);
  assign bus.ready = w_done;
  assign bus.busy  = reset_n && (r_state != S_IDLE);
  assign dataM     = w_drive ? r_mem[r_index] : {FETCH_SIZE{1'bz}};

  // Commit write data on the edge that closes WRITE_DONE, unless reset is applied then.
  always_ff @(posedge clk) begin
    if (reset_n && r_state == S_WRITE_DONE) r_mem[r_index] <= dataM;
  end

`ifdef LINE_MEM_CNT_EN
  logic [WORD_SIZE-1:0] r_rdCnt;
  logic [WORD_SIZE-1:0] r_wrCnt;

  // Completed-transfer counters. They are cleared by reset and wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdCnt <= '0;
      r_wrCnt <= '0;
    end else begin
      if (r_state == S_READ_DONE)  r_rdCnt <= r_rdCnt + 1'b1;
      if (r_state == S_WRITE_DONE) r_wrCnt <= r_wrCnt + 1'b1;
    end
  end

  assign bus.rd_cnt = r_rdCnt;
  assign bus.wr_cnt = r_wrCnt;
`else
  assign bus.rd_cnt = '0;
  assign bus.wr_cnt = '0;
`endif

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Memory-side responder for the cache's line-fill/write-back port. Accepts one line request at a time from the cache (`readM`/`writeM` + `addressM`) and serves a 64-bit, 4-word line after a fixed, parameterised latency. Read lines are driven onto the shared bidirectional `dataM` bus. Write lines are captured from the same bus. A one-cycle `ready` pulse completes each transfer. One instance sits behind the I-cache and one behind the D-cache.

## Interface
Parameters:
- `WORD_SIZE`, 16: address and word width.
- `FETCH_SIZE`, 64: line width (4 words).
- `LINE_ADDR_BITS`, 8: line-array depth is 2^LINE_ADDR_BITS lines, indexed by `addressM[LINE_ADDR_BITS+1:2]`.
- `LATENCY`, 4: cycles from request acceptance to the `ready` cycle; legal range 2..15.

Ports. Reset is synchronous and active-low: `reset_n` is sampled only on the rising edge of `clk`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: synchronous active-low reset.
- `readM` in 1: line read request; level, held by the requester until `ready`.
- `writeM` in 1: line write request; level, held until `ready`.
- `addressM` in WORD_SIZE: word address. Bits [1:0] are ignored; bits above the index are ignored (aliasing).
- `dataM` inout FETCH_SIZE: line bus. Driven by this block only in READ_DONE, otherwise high-Z.
- `ready` out 1: one-cycle completion pulse.
- `busy` out 1: high in every non-IDLE state.
- `rd_cnt` out WORD_SIZE: count of completed reads (only with `LINE_MEM_CNT_EN`).
- `wr_cnt` out WORD_SIZE: count of completed writes (only with `LINE_MEM_CNT_EN`).

## Operation
- **States:** IDLE, READ_WAIT, READ_DONE, WRITE_WAIT, WRITE_DONE. The state register is 3 bits. The wait counter is 4 bits.
- **IDLE:**
  - `writeM` high: latch the line index, load counter with LATENCY-2, go to WRITE_WAIT.
  - Else `readM` high: latch the line index, load counter, go to READ_WAIT.
  - Both high: the write wins and the read is ignored.
- **READ_WAIT / WRITE_WAIT:** decrement the counter each cycle. At 0, go to READ_DONE / WRITE_DONE. When LATENCY=2, the counter starts at 0, so this is a single wait cycle.
- **READ_DONE:** drive `dataM` = `mem[latched index]` and assert `ready`. Next state is IDLE.
- **WRITE_DONE:** assert `ready`. Write `mem[latched index]` <= `dataM` on the closing edge of this cycle. Next state is IDLE.
- **Latched address:** the address captured at acceptance is used throughout. Changes to `addressM` mid-transfer are ignored.
- **Dropped request:** if `readM`/`writeM` deasserts mid-transfer, the transfer still completes, `ready` still pulses, and a write still commits whatever is on `dataM`.
- **Word order on the line:** word 0 is [15:0] and word 3 is [63:48]. The line is stored and returned unmodified.
- **Array contents:** the array has no reset; contents are undefined until written or preloaded by the bench via hierarchical access.
- **Reset values:** state IDLE, `ready`=0, `busy`=0, `dataM` high-Z, counters 0. Array contents are preserved.
- **Reset mid-transfer:** the transfer is abandoned and no array write occurs, including when reset is asserted during WRITE_DONE. `ready` does not pulse.

## Timing
- **Request accepted in cycle T** (IDLE with a request sampled at the edge ending T):
  - State is WAIT in cycles T+1..T+LATENCY-1.
  - `ready` is high in cycle T+LATENCY only.
- **Read data:** valid on `dataM` exactly during the `ready` cycle. The requester samples it on the edge that ends that cycle.
- **Write data:** the requester must hold `dataM` valid at least during the `ready` cycle. Driving it from acceptance onward is permitted.
- **Next request:** the block is in IDLE in cycle T+LATENCY+1. If a request is still high there, it is accepted as a new transfer. The requester must therefore deassert `readM`/`writeM` by the cycle after `ready`. Minimum spacing between acceptances is LATENCY+1 cycles.
- **`busy`:** high from T+1 through T+LATENCY inclusive.
- **Bus turnaround:** `dataM` returns to high-Z in the cycle after READ_DONE.

## Configuration
- **`LINE_MEM_CNT_EN` defined:**
  - `rd_cnt` increments on each READ_DONE cycle; `wr_cnt` increments on each WRITE_DONE cycle.
  - Both are 16-bit and wrap from 0xFFFF to 0.
  - Both are cleared by reset.
- **`LINE_MEM_CNT_EN` undefined:** `rd_cnt` and `wr_cnt` are tied to 0, no counter flops are built, and all other behaviour is unchanged.

## Test plan
- **Read latency, LATENCY=4:** preload line 0x05 = 0x4444_3333_2222_1111, assert `readM` with `addressM`=0x0014 at cycle 0 → `ready` high only in cycle 4, `dataM`=0x4444_3333_2222_1111 in cycle 4, high-Z in cycle 5.
- **Write then read:** `writeM` with `addressM`=0x0023 and `dataM`=0xDEAD_BEEF_0123_4567 held through `ready` → `ready` in cycle 4. A read of 0x0020 afterwards returns 0xDEAD_BEEF_0123_4567; the array write uses line 0x08 regardless of offset bits.
- **Simultaneous request:** `readM`=`writeM`=1 in IDLE → a write occurs, the bus is never driven by the block, `wr_cnt`=1, `rd_cnt`=0.
- **Reset mid-write:** assert `reset_n`=0 in WRITE_DONE → the line keeps its old value, no `ready` pulse, state IDLE, `busy`=0.
- **Address change and back-to-back:** change `addressM` mid-transfer, then issue back-to-back reads → data comes from the latched line. A request held one cycle past `ready` is re-accepted at T+LATENCY+1, with the second `ready` at T+2·LATENCY+1.
- **Counter wrap (with `LINE_MEM_CNT_EN`):** force `rd_cnt`=0xFFFF, complete one read → `rd_cnt`=0x0000.
